// File: rtl/lpm_table_reg_ctrl_if.sv
// Host register bus plus LPM table read/write port for lpm_table_reg_ctrl.
// slave is the controller's view; master is the host/table environment view.
interface lpm_table_reg_ctrl_if #(
    parameter int NUM_QUEUES     = 5,
    parameter int LUT_DEPTH_BITS = 5
);
    logic                      reg_req;
    logic                      reg_rd_wr_L;
    logic [2:0]                reg_addr;
    logic [31:0]               reg_wr_data;
    logic                      reg_ack;
    logic [31:0]               reg_rd_data;

    logic [LUT_DEPTH_BITS-1:0] lpm_rd_addr;
    logic                      lpm_rd_req;
    logic [31:0]               lpm_rd_ip;
    logic [31:0]               lpm_rd_mask;
    logic [31:0]               lpm_rd_next_hop_ip;
    logic [NUM_QUEUES-1:0]     lpm_rd_oq;
    logic                      lpm_rd_ack;

    logic [LUT_DEPTH_BITS-1:0] lpm_wr_addr;
    logic                      lpm_wr_req;
    logic [31:0]               lpm_wr_ip;
    logic [31:0]               lpm_wr_mask;
    logic [31:0]               lpm_wr_next_hop_ip;
    logic [NUM_QUEUES-1:0]     lpm_wr_oq;
    logic                      lpm_wr_ack;

    modport slave (
        input  reg_req, reg_rd_wr_L, reg_addr, reg_wr_data,
        output reg_ack, reg_rd_data,
        output lpm_rd_addr, lpm_rd_req,
        input  lpm_rd_ip, lpm_rd_mask, lpm_rd_next_hop_ip, lpm_rd_oq, lpm_rd_ack,
        output lpm_wr_addr, lpm_wr_req,
        output lpm_wr_ip, lpm_wr_mask, lpm_wr_next_hop_ip, lpm_wr_oq,
        input  lpm_wr_ack
    );

    modport master (
        output reg_req, reg_rd_wr_L, reg_addr, reg_wr_data,
        input  reg_ack, reg_rd_data,
        input  lpm_rd_addr, lpm_rd_req,
        output lpm_rd_ip, lpm_rd_mask, lpm_rd_next_hop_ip, lpm_rd_oq, lpm_rd_ack,
        input  lpm_wr_addr, lpm_wr_req,
        input  lpm_wr_ip, lpm_wr_mask, lpm_wr_next_hop_ip, lpm_wr_oq,
        output lpm_wr_ack
    );
endinterface

// File: rtl/lpm_table_reg_ctrl.sv
// Host register front end for the LPM route table: shadows entry fields and runs table reads/writes.
// Optional ack timeout enabled by defining LPM_REG_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | accepting host accesses, 1-cycle completion for plain registers
// RD_WAIT | table read issued, waiting for lpm_rd_ack
// WR_WAIT | table write issued, waiting for lpm_wr_ack
// DONE    | reg_ack presented for the finished table transaction
module lpm_table_reg_ctrl #(
    parameter int NUM_QUEUES     = 5,
    parameter int LUT_DEPTH      = 32,
    parameter int LUT_DEPTH_BITS = $clog2(LUT_DEPTH)
`ifdef LPM_REG_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic clk,
    input  logic reset,
    lpm_table_reg_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

    state_t                    state_q, state_d;
    logic [31:0]               ip_q, ip_d;
    logic [31:0]               mask_q, mask_d;
    logic [31:0]               nh_q, nh_d;
    logic [NUM_QUEUES-1:0]     oq_q, oq_d;
    logic [LUT_DEPTH_BITS-1:0] rd_idx_q, rd_idx_d;
    logic [LUT_DEPTH_BITS-1:0] wr_idx_q, wr_idx_d;
    logic                      rd_req_q, rd_req_d;
    logic                      wr_req_q, wr_req_d;
    logic                      ack_q, ack_d;
    logic [31:0]               rdata_q, rdata_d;
    logic                      ign_q, ign_d;
    logic                      to_flag;
    logic [31:0]               rd_mux;

`ifdef LPM_REG_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;
    assign to_flag = to_q;
`else
    assign to_flag = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (bus.reg_addr)
            3'd0:    rd_mux = ip_q;
            3'd1:    rd_mux = mask_q;
            3'd2:    rd_mux = nh_q;
            3'd3:    rd_mux = 32'(oq_q);
            3'd4:    rd_mux = 32'(rd_idx_q);
            3'd5:    rd_mux = 32'(wr_idx_q);
            3'd6:    rd_mux = {29'd0, ign_q, to_flag, 1'b0};
            default: rd_mux = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ip_d     = ip_q;
        mask_d   = mask_q;
        nh_d     = nh_q;
        oq_d     = oq_q;
        rd_idx_d = rd_idx_q;
        wr_idx_d = wr_idx_q;
        ign_d    = ign_q;
        rd_req_d = 1'b0;
        wr_req_d = 1'b0;
        ack_d    = 1'b0;
        rdata_d  = '0;
`ifdef LPM_REG_TIMEOUT_EN
        cnt_d    = cnt_q;
        to_d     = to_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.reg_req) begin
                    if (bus.reg_rd_wr_L) begin
                        ack_d   = 1'b1;
                        rdata_d = rd_mux;
                        if (bus.reg_addr == 3'd6) begin
                            ign_d = 1'b0;
`ifdef LPM_REG_TIMEOUT_EN
                            to_d  = 1'b0;
`endif
                        end
                    end else begin
                        case (bus.reg_addr)
                            3'd0: begin ip_d   = bus.reg_wr_data; ack_d = 1'b1; end
                            3'd1: begin mask_d = bus.reg_wr_data; ack_d = 1'b1; end
                            3'd2: begin nh_d   = bus.reg_wr_data; ack_d = 1'b1; end
                            3'd3: begin oq_d   = bus.reg_wr_data[NUM_QUEUES-1:0]; ack_d = 1'b1; end
                            3'd4: begin
                                rd_idx_d = bus.reg_wr_data[LUT_DEPTH_BITS-1:0];
                                rd_req_d = 1'b1;
                                state_d  = RD_WAIT;
`ifdef LPM_REG_TIMEOUT_EN
                                cnt_d    = CNT_W'(TIMEOUT_CYCLES);
`endif
                            end
                            3'd5: begin
                                wr_idx_d = bus.reg_wr_data[LUT_DEPTH_BITS-1:0];
                                wr_req_d = 1'b1;
                                state_d  = WR_WAIT;
`ifdef LPM_REG_TIMEOUT_EN
                                cnt_d    = CNT_W'(TIMEOUT_CYCLES);
`endif
                            end
                            default: ack_d = 1'b1;
                        endcase
                    end
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (bus.reg_req) ign_d = 1'b1;
                // Only the ack matching the pending transaction is honoured.
                if (state_q == RD_WAIT && bus.lpm_rd_ack) begin
                    ip_d    = bus.lpm_rd_ip;
                    mask_d  = bus.lpm_rd_mask;
                    nh_d    = bus.lpm_rd_next_hop_ip;
                    oq_d    = bus.lpm_rd_oq;
                    ack_d   = 1'b1;
                    state_d = DONE;
                end else if (state_q == WR_WAIT && bus.lpm_wr_ack) begin
                    ack_d   = 1'b1;
                    state_d = DONE;
                end
`ifdef LPM_REG_TIMEOUT_EN
                else if (cnt_q <= CNT_W'(1)) begin
                    to_d    = 1'b1;
                    ack_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
`endif
            end
            DONE: begin
                if (bus.reg_req) ign_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ip_q     <= '0;
            mask_q   <= '0;
            nh_q     <= '0;
            oq_q     <= '0;
            rd_idx_q <= '0;
            wr_idx_q <= '0;
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            ign_q    <= 1'b0;
`ifdef LPM_REG_TIMEOUT_EN
            cnt_q    <= '0;
            to_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ip_q     <= ip_d;
            mask_q   <= mask_d;
            nh_q     <= nh_d;
            oq_q     <= oq_d;
            rd_idx_q <= rd_idx_d;
            wr_idx_q <= wr_idx_d;
            rd_req_q <= rd_req_d;
            wr_req_q <= wr_req_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            ign_q    <= ign_d;
`ifdef LPM_REG_TIMEOUT_EN
            cnt_q    <= cnt_d;
            to_q     <= to_d;
`endif
        end
    end

    assign bus.reg_ack            = ack_q;
    assign bus.reg_rd_data        = rdata_q;
    assign bus.lpm_rd_addr        = rd_idx_q;
    assign bus.lpm_rd_req         = rd_req_q;
    assign bus.lpm_wr_addr        = wr_idx_q;
    assign bus.lpm_wr_req         = wr_req_q;
    assign bus.lpm_wr_ip          = ip_q;
    assign bus.lpm_wr_mask        = mask_q;
    assign bus.lpm_wr_next_hop_ip = nh_q;
    assign bus.lpm_wr_oq          = oq_q;

endmodule

// File: tb/tb_lpm_table_reg_ctrl.sv
// Scoreboard bench for lpm_table_reg_ctrl: expected acks and table requests are queued by stimulus
// and checked by negedge monitors. Timeout scenario runs when LPM_REG_TIMEOUT_EN is defined.
module tb_lpm_table_reg_ctrl;
    localparam int NQ  = 5;
    localparam int LDB = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lpm_table_reg_ctrl_if #(.NUM_QUEUES(NQ), .LUT_DEPTH_BITS(LDB)) bus ();

    lpm_table_reg_ctrl #(
        .NUM_QUEUES(NQ),
        .LUT_DEPTH(32)
`ifdef LPM_REG_TIMEOUT_EN
       ,.TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct packed {
        logic [LDB-1:0] addr;
        logic [31:0]    ip;
        logic [31:0]    mask;
        logic [31:0]    nh;
        logic [NQ-1:0]  oq;
    } wr_exp_t;

    logic [31:0]    ack_exp_q[$];
    logic [LDB-1:0] rd_exp_q[$];
    wr_exp_t        wr_exp_q[$];

    int tests = 0;
    int failures = 0;
    int cyc = 0;
    int ack_cnt = 0;
    int last_ack_cyc = 0;
    int rd_req_cnt = 0;
    int wr_req_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Host-side monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.reg_ack) begin
                ack_cnt++;
                last_ack_cyc = cyc;
                if (ack_exp_q.size() == 0) check("unexpected reg_ack", 32'd1, 32'd0);
                else check("reg_rd_data", bus.reg_rd_data, ack_exp_q.pop_front());
            end else if (bus.reg_rd_data != 32'd0) begin
                check("rd_data idle zero", bus.reg_rd_data, 32'd0);
            end
        end
    end

    // Table-side monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.lpm_rd_req) begin
                rd_req_cnt++;
                if (rd_exp_q.size() == 0) check("unexpected lpm_rd_req", 32'd1, 32'd0);
                else check("lpm_rd_addr", 32'(bus.lpm_rd_addr), 32'(rd_exp_q.pop_front()));
            end
            if (bus.lpm_wr_req) begin
                wr_exp_t e;
                wr_req_cnt++;
                if (wr_exp_q.size() == 0) check("unexpected lpm_wr_req", 32'd1, 32'd0);
                else begin
                    e = wr_exp_q.pop_front();
                    check("lpm_wr_addr", 32'(bus.lpm_wr_addr), 32'(e.addr));
                    check("lpm_wr_ip",   bus.lpm_wr_ip, e.ip);
                    check("lpm_wr_mask", bus.lpm_wr_mask, e.mask);
                    check("lpm_wr_nh",   bus.lpm_wr_next_hop_ip, e.nh);
                    check("lpm_wr_oq",   32'(bus.lpm_wr_oq), 32'(e.oq));
                end
            end
        end
    end

    task automatic host(input logic rd, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.reg_req     = 1'b1;
        bus.reg_rd_wr_L = rd;
        bus.reg_addr    = a;
        bus.reg_wr_data = d;
        @(negedge clk);
        bus.reg_req     = 1'b0;
    endtask

    task automatic wait_acks(input string name, input int n0);
        for (int i = 0; i < 30 && ack_cnt == n0; i++) @(negedge clk);
        check(name, 32'(ack_cnt - n0), 32'd1);
    endtask

    task automatic access(input logic rd, input logic [2:0] a, input logic [31:0] d,
                          input logic [31:0] exp, input string name);
        int n0;
        n0 = ack_cnt;
        ack_exp_q.push_back(exp);
        host(rd, a, d);
        wait_acks(name, n0);
    endtask

    task automatic wait_req(input string name, input int n0, input logic is_rd);
        for (int i = 0; i < 30 && (is_rd ? rd_req_cnt : wr_req_cnt) == n0; i++) @(negedge clk);
        check(name, 32'((is_rd ? rd_req_cnt : wr_req_cnt) - n0), 32'd1);
    endtask

    initial begin
        int n0, r0, w0, drv_cyc, c0;
        bus.reg_req = 1'b0; bus.reg_rd_wr_L = 1'b0; bus.reg_addr = '0; bus.reg_wr_data = '0;
        bus.lpm_rd_ip = '0; bus.lpm_rd_mask = '0; bus.lpm_rd_next_hop_ip = '0; bus.lpm_rd_oq = '0;
        bus.lpm_rd_ack = 1'b0; bus.lpm_wr_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset reg_ack", 32'(bus.reg_ack), 32'd0);
        check("reset lpm_wr_ip", bus.lpm_wr_ip, 32'd0);
        check("reset lpm_rd_req", 32'(bus.lpm_rd_req), 32'd0);
        reset = 1'b0;

        // Program an entry and write it to index 3
        access(1'b0, 3'd0, 32'h0A000000, 32'd0, "ack ip write");
        access(1'b0, 3'd1, 32'hFF000000, 32'd0, "ack mask write");
        access(1'b0, 3'd2, 32'h0A000001, 32'd0, "ack nh write");
        access(1'b0, 3'd3, 32'h00000004, 32'd0, "ack oq write");
        wr_exp_q.push_back('{addr: 5'd3, ip: 32'h0A000000, mask: 32'hFF000000,
                             nh: 32'h0A000001, oq: 5'h04});
        ack_exp_q.push_back(32'd0);
        n0 = ack_cnt; w0 = wr_req_cnt;
        host(1'b0, 3'd5, 32'd3);
        wait_req("wr_req issued", w0, 1'b0);
        repeat (4) @(negedge clk);
        check("no early ack", 32'(ack_cnt - n0), 32'd0);
        bus.lpm_wr_ack = 1'b1; drv_cyc = cyc;
        @(negedge clk);
        bus.lpm_wr_ack = 1'b0;
        wait_acks("wr completion ack", n0);
        check("ack latency", 32'(last_ack_cyc - drv_cyc), 32'd1);
        check("single wr_req pulse", 32'(wr_req_cnt - w0), 32'd1);

        // Read index 0x23 -> 3; wr_ack in same cycle must be ignored
        rd_exp_q.push_back(5'd3);
        ack_exp_q.push_back(32'd0);
        n0 = ack_cnt; r0 = rd_req_cnt;
        host(1'b0, 3'd4, 32'h23);
        wait_req("rd_req issued", r0, 1'b1);
        @(negedge clk);
        bus.lpm_rd_ip = 32'hC0A80000; bus.lpm_rd_mask = 32'hFFFF0000;
        bus.lpm_rd_next_hop_ip = 32'd0; bus.lpm_rd_oq = 5'h10;
        bus.lpm_rd_ack = 1'b1; bus.lpm_wr_ack = 1'b1;
        @(negedge clk);
        bus.lpm_rd_ack = 1'b0; bus.lpm_wr_ack = 1'b0;
        wait_acks("rd completion ack", n0);
        access(1'b1, 3'd0, 32'd0, 32'hC0A80000, "ack ip read");
        access(1'b1, 3'd1, 32'd0, 32'hFFFF0000, "ack mask read");
        access(1'b1, 3'd2, 32'd0, 32'h00000000, "ack nh read");
        access(1'b1, 3'd3, 32'd0, 32'h00000010, "ack oq read");
        access(1'b1, 3'd4, 32'd0, 32'h00000003, "ack rd_addr read");
        access(1'b1, 3'd5, 32'd0, 32'h00000003, "ack wr_addr read");
        check("shadow on lpm_wr_ip", bus.lpm_wr_ip, 32'hC0A80000);

        // Ack in the same cycle as the request
        rd_exp_q.push_back(5'd5);
        ack_exp_q.push_back(32'd0);
        n0 = ack_cnt;
        @(negedge clk);
        bus.reg_req = 1'b1; bus.reg_rd_wr_L = 1'b0; bus.reg_addr = 3'd4; bus.reg_wr_data = 32'd5;
        @(negedge clk);
        bus.reg_req = 1'b0;
        bus.lpm_rd_ip = 32'h11111111; bus.lpm_rd_mask = 32'hFFFFFF00;
        bus.lpm_rd_next_hop_ip = 32'h22222222; bus.lpm_rd_oq = 5'h01;
        bus.lpm_rd_ack = 1'b1;
        @(negedge clk);
        bus.lpm_rd_ack = 1'b0;
        wait_acks("same-cycle ack", n0);
        access(1'b1, 3'd0, 32'd0, 32'h11111111, "ack ip after fast read");
        access(1'b1, 3'd2, 32'd0, 32'h22222222, "ack nh after fast read");

        // OQ truncation and reserved address
        access(1'b0, 3'd3, 32'hFFFFFFFF, 32'd0, "ack oq all-ones write");
        access(1'b1, 3'd3, 32'd0, 32'h0000001F, "ack oq truncated read");
        access(1'b0, 3'd7, 32'hDEADBEEF, 32'd0, "ack reserved write");
        access(1'b1, 3'd7, 32'd0, 32'd0, "ack reserved read");

        // Host access while waiting is ignored and flagged
        wr_exp_q.push_back('{addr: 5'd7, ip: 32'h11111111, mask: 32'hFFFFFF00,
                             nh: 32'h22222222, oq: 5'h1F});
        ack_exp_q.push_back(32'd0);
        n0 = ack_cnt; w0 = wr_req_cnt;
        host(1'b0, 3'd5, 32'd7);
        host(1'b0, 3'd0, 32'h12345678);
        repeat (3) @(negedge clk);
        check("ignored req no ack", 32'(ack_cnt - n0), 32'd0);
        check("no reissue", 32'(wr_req_cnt - w0), 32'd1);
        bus.lpm_wr_ack = 1'b1;
        @(negedge clk);
        bus.lpm_wr_ack = 1'b0;
        wait_acks("wr ack after ignored", n0);
        access(1'b1, 3'd0, 32'd0, 32'h11111111, "ack ip unchanged");
        access(1'b1, 3'd6, 32'd0, 32'h00000004, "ack status ignored");
        access(1'b1, 3'd6, 32'd0, 32'h00000000, "ack status cleared");

        // Stray ack in IDLE does not touch shadows
        @(negedge clk);
        bus.lpm_rd_ip = 32'hAAAAAAAA; bus.lpm_rd_ack = 1'b1;
        @(negedge clk);
        bus.lpm_rd_ack = 1'b0;
        access(1'b1, 3'd0, 32'd0, 32'h11111111, "ack ip after stray ack");

        // Reset mid read
        rd_exp_q.push_back(5'd9);
        n0 = ack_cnt;
        host(1'b0, 3'd4, 32'd9);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst lpm_rd_addr", 32'(bus.lpm_rd_addr), 32'd0);
        check("rst lpm_wr_ip", bus.lpm_wr_ip, 32'd0);
        check("rst lpm_wr_mask", bus.lpm_wr_mask, 32'd0);
        check("rst lpm_wr_oq", 32'(bus.lpm_wr_oq), 32'd0);
        check("rst reg_ack", 32'(bus.reg_ack), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.lpm_rd_ip = 32'hBBBBBBBB; bus.lpm_rd_ack = 1'b1;
        @(negedge clk);
        bus.lpm_rd_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("no ack after reset", 32'(ack_cnt - n0), 32'd0);
        access(1'b1, 3'd0, 32'd0, 32'd0, "ack ip after reset");
        access(1'b1, 3'd4, 32'd0, 32'd0, "ack rd_addr after reset");

`ifdef LPM_REG_TIMEOUT_EN
        wr_exp_q.push_back('{addr: 5'd1, ip: 32'd0, mask: 32'd0, nh: 32'd0, oq: 5'd0});
        ack_exp_q.push_back(32'd0);
        n0 = ack_cnt;
        @(negedge clk);
        c0 = cyc;
        bus.reg_req = 1'b1; bus.reg_rd_wr_L = 1'b0; bus.reg_addr = 3'd5; bus.reg_wr_data = 32'd1;
        @(negedge clk);
        bus.reg_req = 1'b0;
        wait_acks("timeout ack", n0);
        check("timeout within 10", 32'(last_ack_cyc - c0 <= 10), 32'd1);
        bus.lpm_wr_ack = 1'b1;
        @(negedge clk);
        bus.lpm_wr_ack = 1'b0;
        access(1'b1, 3'd6, 32'd0, 32'h00000002, "ack status timeout");
        access(1'b1, 3'd6, 32'd0, 32'h00000000, "ack status timeout cleared");
`else
        c0 = 0;
        access(1'b1, 3'd6, 32'd0, 32'h00000000, "ack status final");
`endif

        repeat (2) @(negedge clk);
        check("ack queue drained", 32'(ack_exp_q.size()), 32'd0);
        check("rd queue drained", 32'(rd_exp_q.size()), 32'd0);
        check("wr queue drained", 32'(wr_exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lpm_table_reg_ctrl.md
Name: lpm_table_reg_ctrl

Overview:
Host-side register front end for the LPM route table. It turns single-word host register accesses into table read/write transactions on the lookup block's table port (lpm_rd_*/lpm_wr_*), waits for the table's acks, and stages entry fields in shadow registers. It is the initiator for that port.

Parameters:
NUM_QUEUES, 5, width of output-queue field
LUT_DEPTH, 32, route table entries (power of two)
LUT_DEPTH_BITS, log2(LUT_DEPTH), table index width
TIMEOUT_CYCLES, 64, ack timeout (used only with LPM_REG_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  reset
reg_req  in  1  one-cycle host access strobe
reg_rd_wr_L  in  1  1=read, 0=write
reg_addr  in  3  word address (map below)
reg_wr_data  in  32  host write data
reg_ack  out  1  one-cycle completion pulse
reg_rd_data  out  32  read data, valid with reg_ack
lpm_rd_addr  out  LUT_DEPTH_BITS  table read index
lpm_rd_req  out  1  one-cycle table read request
lpm_rd_ip, lpm_rd_mask, lpm_rd_next_hop_ip  in  32 each  read-back entry fields
lpm_rd_oq  in  NUM_QUEUES  read-back output queue
lpm_rd_ack  in  1  table read done
lpm_wr_addr  out  LUT_DEPTH_BITS  table write index
lpm_wr_req  out  1  one-cycle table write request
lpm_wr_ip, lpm_wr_mask, lpm_wr_next_hop_ip  out  32 each  entry fields, driven from shadows
lpm_wr_oq  out  NUM_QUEUES  entry output queue
lpm_wr_ack  in  1  table write done

Behaviour:
- Single clock clk. Reset is asynchronous and active-high. All flops clear on reset: shadows=0, outputs 0, state IDLE, sticky flags 0.
- Register map:
  - 0 IP.
  - 1 MASK.
  - 2 NEXT_HOP.
  - 3 OQ: writes truncate to NUM_QUEUES bits; reads zero-extend.
  - 4 RD_ADDR: write triggers a table read.
  - 5 WR_ADDR: write triggers a table write.
  - 6 STATUS: bit0 busy (always 0 when readable), bit1 timeout sticky (clear-on-read), bit2 ignored-request sticky (clear-on-read).
  - 7 reserved: reads 0, writes dropped.
- RD_ADDR/WR_ADDR writes use reg_wr_data[LUT_DEPTH_BITS-1:0]; upper bits are ignored. Reads of 4/5 return the last index, zero-extended.
- lpm_wr_ip/mask/next_hop/oq continuously reflect the shadows. MASK is stored and presented as a true mask (1=care).
- FSM states: IDLE, RD_WAIT, WR_WAIT, DONE.
- IDLE, reg_req to address 0-3, 6 or 7: access completes in 1 cycle. reg_req at T -> reg_ack at T+1 with reg_rd_data. Stay in IDLE.
- IDLE, write to 4: latch index; lpm_rd_req pulses at T+1; go to RD_WAIT.
  - On lpm_rd_ack at cycle A: capture lpm_rd_ip/mask/next_hop_ip/oq into the shadows; go to DONE.
  - reg_ack at A+1; return to IDLE.
- IDLE, write to 5: latch index; lpm_wr_req pulses at T+1; go to WR_WAIT.
  - lpm_wr_ack at A -> DONE -> reg_ack at A+1.
- Request pulses are exactly one cycle. The block never re-issues a request while waiting.
- reg_req while not IDLE: no ack, no state change, set STATUS bit2.
- Ack inputs received in IDLE, or ack of the wrong kind: ignored.
- lpm_rd_ack and lpm_wr_ack asserted in the same cycle: only the one matching the current state is honoured.
- Ack in the same cycle as the request (cycle T+1): accepted.
- reg_rd_data is 0 whenever reg_ack is low.
- Asynchronous reset mid-transaction: abort immediately; no reg_ack is produced.

Optional Feature:
LPM_REG_TIMEOUT_EN
- Defined: a counter runs in RD_WAIT/WR_WAIT. If no ack arrives after TIMEOUT_CYCLES cycles, go to DONE, set STATUS bit1, and pulse reg_ack.
  - Shadows are unchanged on a read timeout.
  - A later stray ack is ignored.
- Undefined: wait indefinitely; STATUS bit1 reads 0 and no counter is synthesised.

Test Plan:
- Write IP=0x0A000000, MASK=0xFF000000, NEXT_HOP=0x0A000001, OQ=0x04, then WR_ADDR=3 -> one lpm_wr_req pulse with lpm_wr_addr=3, lpm_wr_ip=0x0A000000, lpm_wr_mask=0xFF000000, lpm_wr_oq=5'h04. Table acks 5 cycles later -> reg_ack exactly 1 cycle after lpm_wr_ack.
- Write RD_ADDR=0x23 with LUT_DEPTH=32 -> lpm_rd_addr=3. Bench returns ip=0xC0A80000, mask=0xFFFF0000, oq=0x10, nh=0 with ack -> subsequent reads of addresses 0..3 return those values.
- Write OQ=0xFFFFFFFF -> read OQ returns 0x0000001F.
- reg_req to IP during WR_WAIT -> no reg_ack and IP unchanged; after completion STATUS reads 0x4, then reads 0x0.
- Assert reset 2 cycles into RD_WAIT -> all outputs 0 immediately; no reg_ack; an ack arriving after reset is ignored.
- With LPM_REG_TIMEOUT_EN and TIMEOUT_CYCLES=8, write WR_ADDR and never ack -> reg_ack within 10 cycles of the request; STATUS reads 0x2, then 0x0.
